// File: rtl/fetch_warp_sched.sv
// Per-core warp fetch scheduler: per-warp PC/mask/lifecycle state plus a round-robin pick
// into a registered valid/ready request. Define FETCH_SCHED_PERF_EN to build the perf counters.
module fetch_warp_sched #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int UUID_WIDTH  = 16,
  parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spawn_valid,
  input  logic [NW_WIDTH-1:0]    spawn_wid,
  input  logic [XLEN-1:0]        spawn_pc,
  input  logic [NUM_THREADS-1:0] spawn_tmask,
  input  logic                   unlock_valid,
  input  logic [NW_WIDTH-1:0]    unlock_wid,
  input  logic                   unlock_redirect,
  input  logic [XLEN-1:0]        unlock_pc,
  input  logic                   unlock_tmask_en,
  input  logic [NUM_THREADS-1:0] unlock_tmask,
  output logic                   sched_valid,
  input  logic                   sched_ready,
  output logic [NW_WIDTH-1:0]    sched_wid,
  output logic [XLEN-1:0]        sched_pc,
  output logic [NUM_THREADS-1:0] sched_tmask,
  output logic [UUID_WIDTH-1:0]  sched_uuid,
  output logic [NUM_WARPS-1:0]   active_warps,
  output logic                   busy,
  output logic [31:0]            perf_idle_cycles,
  output logic [31:0]            perf_stall_cycles
);

  logic [NUM_WARPS-1:0]   active_q;
  logic [NUM_WARPS-1:0]   inflight_q;
  logic [XLEN-1:0]        pc_q    [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
  logic [NW_WIDTH-1:0]    rr_ptr_q;
  logic [UUID_WIDTH-1:0]  uuid_ctr_q;

  logic [NUM_WARPS-1:0]   eligible;
  logic [NW_WIDTH-1:0]    cand;
  logic [NW_WIDTH-1:0]    pick_wid;
  logic                   pick_found;
  logic                   load_en;
  logic                   do_load;
  logic                   unlock_ok;
  logic                   unlock_kill;
  logic                   spawn_ok;

  assign eligible = active_q & ~inflight_q;

  // Round-robin search starting one past the last loaded warp; the index wraps naturally
  // because NUM_WARPS is a power of two.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    pick_found = 1'b0;
    pick_wid   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      cand = rr_ptr_q + NW_WIDTH'(i);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_wid   = cand;
      end
    end
  end

  assign load_en = !sched_valid || sched_ready;
  assign do_load = load_en && pick_found;

  // The warp sitting in the output register has not reached decode yet, so it cannot be released.
  assign unlock_ok   = unlock_valid && active_q[unlock_wid] && inflight_q[unlock_wid] &&
                       !(sched_valid && (sched_wid == unlock_wid));
  assign unlock_kill = unlock_ok && unlock_tmask_en && (unlock_tmask == '0);
  assign spawn_ok    = spawn_valid && (spawn_tmask != '0) &&
                       (!active_q[spawn_wid] || (unlock_kill && (unlock_wid == spawn_wid)));

  // Statement order encodes priority: unlock, then spawn (respawn after terminate), then load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q   <= '0;
      inflight_q <= '0;
      // NOTE: per-warp PC/mask live in flops, not a RAM, so they are cleared to keep X off the payload.
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w]    <= '0;
        tmask_q[w] <= '0;
      end
    end else begin
      if (unlock_ok) begin
        inflight_q[unlock_wid] <= 1'b0;
        if (unlock_redirect) pc_q[unlock_wid] <= unlock_pc;
        if (unlock_tmask_en) tmask_q[unlock_wid] <= unlock_tmask;
        if (unlock_kill)     active_q[unlock_wid] <= 1'b0;
      end
      if (spawn_ok) begin
        active_q[spawn_wid]   <= 1'b1;
        inflight_q[spawn_wid] <= 1'b0;
        pc_q[spawn_wid]       <= spawn_pc;
        tmask_q[spawn_wid]    <= spawn_tmask;
      end
      if (do_load) begin
        inflight_q[pick_wid] <= 1'b1;
        pc_q[pick_wid]       <= pc_q[pick_wid] + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sched_valid <= 1'b0;
      sched_wid   <= '0;
      sched_pc    <= '0;
      sched_tmask <= '0;
      sched_uuid  <= '0;
      rr_ptr_q    <= NW_WIDTH'(NUM_WARPS - 1);
      uuid_ctr_q  <= '0;
    end else if (load_en) begin
      sched_valid <= pick_found;
      if (pick_found) begin
        sched_wid   <= pick_wid;
        sched_pc    <= pc_q[pick_wid];
        sched_tmask <= tmask_q[pick_wid];
        sched_uuid  <= uuid_ctr_q;
        rr_ptr_q    <= pick_wid;
        uuid_ctr_q  <= uuid_ctr_q + UUID_WIDTH'(1);
      end
    end
  end

  assign active_warps = active_q;
  assign busy         = (|active_q) || sched_valid;

`ifdef FETCH_SCHED_PERF_EN
  logic [31:0] idle_q;
  logic [31:0] stall_q;

  // Saturating counters: they stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_q  <= '0;
      stall_q <= '0;
    end else begin
      if ((active_q == '0) && (idle_q != '1))
        idle_q <= idle_q + 32'd1;
      if (sched_valid && !sched_ready && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_idle_cycles  = idle_q;
  assign perf_stall_cycles = stall_q;
`else
  assign perf_idle_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_warp_sched.sv
// Self-checking bench for fetch_warp_sched: scenario tasks with a request scoreboard
// (expected requests queued at stimulus time, popped when a request fires).
module tb_fetch_warp_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        spawn_valid = 1'b0;
  logic [1:0]  spawn_wid = '0;
  logic [31:0] spawn_pc = '0;
  logic [3:0]  spawn_tmask = '0;
  logic        unlock_valid = 1'b0;
  logic [1:0]  unlock_wid = '0;
  logic        unlock_redirect = 1'b0;
  logic [31:0] unlock_pc = '0;
  logic        unlock_tmask_en = 1'b0;
  logic [3:0]  unlock_tmask = '0;
  logic        sched_valid;
  logic        sched_ready = 1'b0;
  logic [1:0]  sched_wid;
  logic [31:0] sched_pc;
  logic [3:0]  sched_tmask;
  logic [15:0] sched_uuid;
  logic [3:0]  active_warps;
  logic        busy;
  logic [31:0] perf_idle_cycles;
  logic [31:0] perf_stall_cycles;

  fetch_warp_sched dut (
    .clk(clk), .reset(reset),
    .spawn_valid(spawn_valid), .spawn_wid(spawn_wid), .spawn_pc(spawn_pc), .spawn_tmask(spawn_tmask),
    .unlock_valid(unlock_valid), .unlock_wid(unlock_wid), .unlock_redirect(unlock_redirect),
    .unlock_pc(unlock_pc), .unlock_tmask_en(unlock_tmask_en), .unlock_tmask(unlock_tmask),
    .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_wid(sched_wid), .sched_pc(sched_pc),
    .sched_tmask(sched_tmask), .sched_uuid(sched_uuid), .active_warps(active_warps), .busy(busy),
    .perf_idle_cycles(perf_idle_cycles), .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

`ifdef FETCH_SCHED_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  wid;
    logic [31:0] pc;
    logic [3:0]  tmask;
    logic [15:0] uuid;
  } req_t;

  typedef struct packed {
    logic [1:0]  wid;
    logic [31:0] pc;
    logic [3:0]  tmask;
  } spawn_t;

  req_t        exp_q[$];
  spawn_t      spawn_q[$];
  logic [15:0] exp_uuid;
  logic [31:0] mpc [4];
  logic [3:0]  tm  [4];
  bit          redir_en [4];
  logic [31:0] redir_pc [4];
  bit          term_en [4];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic req_t dut_req();
    return {sched_wid, sched_pc, sched_tmask, sched_uuid};
  endfunction

  function automatic logic [31:0] base_pc(input int w);
    return 32'h8000_0000 + (w << 12);
  endfunction

  function automatic int count_wid(input logic [1:0] w);
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].wid == w) n++;
    return n;
  endfunction

  task automatic push_exp(input logic [1:0] w, input logic [31:0] pc, input logic [3:0] t);
    req_t e;
    e.wid = w; e.pc = pc; e.tmask = t; e.uuid = exp_uuid;
    exp_uuid = exp_uuid + 16'd1;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    spawn_valid = 1'b0; unlock_valid = 1'b0; unlock_redirect = 1'b0; unlock_tmask_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; sched_ready = 1'b0;
    idle_inputs();
    tick(); tick();
    reset = 1'b1;
    exp_q.delete(); spawn_q.delete();
    exp_uuid = '0;
    for (int w = 0; w < 4; w++) begin
      redir_en[w] = 1'b0; term_en[w] = 1'b0;
      mpc[w] = base_pc(w);
    end
  endtask

  // Drives queued spawns one per cycle, unlocks each warp the cycle after it fires (while it
  // still has expected requests, or when a terminate is armed) and checks every fire.
  task automatic run_stream(input string name, input int max_cycles);
    int     pend = 0;
    bit     have_pend = 1'b0;
    int     drain = 0;
    spawn_t s;
    req_t   e;
    for (int c = 0; c < max_cycles && drain < 8; c++) begin
      if (spawn_q.size() > 0) begin
        s = spawn_q.pop_front();
        spawn_valid = 1'b1; spawn_wid = s.wid; spawn_pc = s.pc; spawn_tmask = s.tmask;
      end else begin
        spawn_valid = 1'b0;
      end
      unlock_valid = 1'b0; unlock_redirect = 1'b0; unlock_tmask_en = 1'b0;
      if (have_pend) begin
        unlock_wid = 2'(pend);
        if (term_en[pend]) begin
          unlock_valid = 1'b1; unlock_tmask_en = 1'b1; unlock_tmask = 4'b0000;
          term_en[pend] = 1'b0;
        end else if (count_wid(2'(pend)) > 0) begin
          unlock_valid = 1'b1;
          if (redir_en[pend]) begin
            unlock_redirect = 1'b1; unlock_pc = redir_pc[pend];
            redir_en[pend] = 1'b0;
          end
        end
        have_pend = 1'b0;
      end
      if (sched_valid && sched_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s unexpected request: got wid=%0d pc=%h uuid=%0d, required none",
                   name, sched_wid, sched_pc, sched_uuid);
        end else begin
          e = exp_q.pop_front();
          if (dut_req() !== e) begin
            n_fail++;
            $display("FAIL %s request: got wid=%0d pc=%h tmask=%b uuid=%0d, required wid=%0d pc=%h tmask=%b uuid=%0d",
                     name, sched_wid, sched_pc, sched_tmask, sched_uuid, e.wid, e.pc, e.tmask, e.uuid);
          end
        end
        pend = int'(sched_wid);
        have_pend = 1'b1;
      end
      if (exp_q.size() == 0 && spawn_q.size() == 0) drain++;
      tick();
    end
    idle_inputs();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d requests still outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({sched_valid, active_warps, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got valid=%b active=%b busy=%b, required 0/0000/0", sched_valid, active_warps, busy);
    end
    n_checks++;
    if (dut_req() !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: got %h, required 0", dut_req());
    end
    n_checks++;
    if (perf_idle_cycles !== 32'd0 || perf_stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_perf: got idle=%0d stall=%0d, required 0/0", perf_idle_cycles, perf_stall_cycles);
    end
    tick(); tick(); tick();
    n_checks++;
    if (perf_idle_cycles !== (PERF_ON ? 32'd3 : 32'd0) || sched_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_count: got idle=%0d valid=%b, required %0d/0", perf_idle_cycles, sched_valid, PERF_ON ? 3 : 0);
    end
  endtask

  task automatic test_single_spawn();
    req_t e;
    do_reset();
    sched_ready = 1'b1;
    spawn_valid = 1'b1; spawn_wid = 2'd0; spawn_pc = 32'h8000_0000; spawn_tmask = 4'b1111;
    push_exp(2'd0, 32'h8000_0000, 4'b1111);
    tick();
    spawn_valid = 1'b0;
    n_checks++;
    if (sched_valid !== 1'b0 || active_warps !== 4'b0001) begin
      n_fail++;
      $display("FAIL spawn_edge1: got valid=%b active=%b, required 0/0001", sched_valid, active_warps);
    end
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (sched_valid !== 1'b1 || dut_req() !== e) begin
      n_fail++;
      $display("FAIL spawn_edge2: got valid=%b req=%h, required 1/%h", sched_valid, dut_req(), e);
    end
    tick();
    n_checks++;
    if (sched_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL no_reissue: got valid=%b busy=%b, required 0/1", sched_valid, busy);
    end
    // Spawn to an active warp and a zero-mask spawn must both be ignored.
    spawn_valid = 1'b1; spawn_wid = 2'd0; spawn_pc = 32'h0000_1234; spawn_tmask = 4'b0011;
    tick();
    spawn_wid = 2'd1; spawn_pc = 32'h0000_5678; spawn_tmask = 4'b0000;
    tick();
    spawn_valid = 1'b0;
    tick(); tick();
    n_checks++;
    if (sched_valid !== 1'b0 || active_warps !== 4'b0001) begin
      n_fail++;
      $display("FAIL ignored_spawn: got valid=%b active=%b, required 0/0001", sched_valid, active_warps);
    end
    unlock_valid = 1'b1; unlock_wid = 2'd0;
    push_exp(2'd0, 32'h8000_0004, 4'b1111);
    tick();
    unlock_valid = 1'b0;
    n_checks++;
    if (sched_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL unlock_edge1: got valid=%b, required 0", sched_valid);
    end
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (sched_valid !== 1'b1 || dut_req() !== e) begin
      n_fail++;
      $display("FAIL unlock_reissue: got valid=%b req=%h, required 1/%h", sched_valid, dut_req(), e);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    sched_ready = 1'b1;
    for (int w = 0; w < 4; w++) spawn_q.push_back({2'(w), base_pc(w), tm[w]});
    for (int r = 0; r < 2; r++)
      for (int w = 0; w < 4; w++) begin
        push_exp(2'(w), mpc[w], tm[w]);
        mpc[w] = mpc[w] + 32'd4;
      end
    run_stream("round_robin", 100);
    n_checks++;
    if (active_warps !== 4'b1111) begin
      n_fail++;
      $display("FAIL rr_active: got %b, required 1111", active_warps);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    sched_ready = 1'b1;
    redir_en[1] = 1'b1; redir_pc[1] = 32'h8000_0100;
    for (int w = 0; w < 4; w++) spawn_q.push_back({2'(w), base_pc(w), tm[w]});
    for (int r = 0; r < 3; r++)
      for (int w = 0; w < 4; w++) begin
        push_exp(2'(w), mpc[w], tm[w]);
        mpc[w] = (r == 0 && w == 1) ? 32'h8000_0100 : mpc[w] + 32'd4;
      end
    run_stream("redirect", 100);
  endtask

  task automatic test_terminate();
    do_reset();
    sched_ready = 1'b1;
    term_en[3] = 1'b1;
    for (int w = 0; w < 4; w++) spawn_q.push_back({2'(w), base_pc(w), tm[w]});
    for (int r = 0; r < 3; r++)
      for (int w = 0; w < 4; w++)
        if (r == 0 || w != 3) begin
          push_exp(2'(w), mpc[w], tm[w]);
          mpc[w] = mpc[w] + 32'd4;
        end
    run_stream("terminate", 100);
    n_checks++;
    if (active_warps !== 4'b0111) begin
      n_fail++;
      $display("FAIL term_active: got %b, required 0111", active_warps);
    end
    spawn_q.push_back({2'd3, 32'h8000_9000, 4'b1010});
    push_exp(2'd3, 32'h8000_9000, 4'b1010);
    run_stream("respawn", 50);
    n_checks++;
    if (active_warps !== 4'b1111) begin
      n_fail++;
      $display("FAIL respawn_active: got %b, required 1111", active_warps);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_stall;
    exp_stall = PERF_ON ? 32'd5 : 32'd0;
    do_reset();
    spawn_valid = 1'b1; spawn_wid = 2'd2; spawn_pc = 32'h8000_2000; spawn_tmask = 4'b0101;
    push_exp(2'd2, 32'h8000_2000, 4'b0101);
    tick();
    spawn_valid = 1'b0;
    tick();
    n_checks++;
    if (sched_valid !== 1'b1 || dut_req() !== exp_q[0]) begin
      n_fail++;
      $display("FAIL stall_first: got valid=%b req=%h, required 1/%h", sched_valid, dut_req(), exp_q[0]);
    end
    // Unlock of the warp still held in the output register must be ignored.
    unlock_valid = 1'b1; unlock_wid = 2'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      unlock_valid = 1'b0;
      n_checks++;
      if (sched_valid !== 1'b1 || dut_req() !== exp_q[0]) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b req=%h, required 1/%h", i, sched_valid, dut_req(), exp_q[0]);
      end
    end
    n_checks++;
    if (perf_stall_cycles !== exp_stall) begin
      n_fail++;
      $display("FAIL stall_count: got %0d, required %0d", perf_stall_cycles, exp_stall);
    end
    sched_ready = 1'b1;
    tick();
    void'(exp_q.pop_front());
    tick(); tick(); tick();
    n_checks++;
    if (sched_valid !== 1'b0 || perf_stall_cycles !== exp_stall) begin
      n_fail++;
      $display("FAIL held_unlock: got valid=%b stall=%0d, required 0/%0d", sched_valid, perf_stall_cycles, exp_stall);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int w = 0; w < 4; w++) begin
      spawn_valid = 1'b1; spawn_wid = 2'(w); spawn_pc = base_pc(w); spawn_tmask = tm[w];
      tick();
    end
    spawn_valid = 1'b0;
    n_checks++;
    if (sched_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_pending: got valid=%b busy=%b, required 1/1", sched_valid, busy);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if ({sched_valid, active_warps, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL midop_reset: got valid=%b active=%b busy=%b, required 0/0000/0", sched_valid, active_warps, busy);
    end
    reset = 1'b1;
    exp_uuid = '0;
    sched_ready = 1'b1;
    spawn_q.push_back({2'd1, 32'h8000_4000, 4'b0011});
    push_exp(2'd1, 32'h8000_4000, 4'b0011);
    run_stream("midop_restart", 50);
  endtask

  initial begin
    tm[0] = 4'b1111; tm[1] = 4'b0011; tm[2] = 4'b0101; tm[3] = 4'b1000;
    test_reset();
    test_single_spawn();
    test_round_robin();
    test_redirect();
    test_terminate();
    test_stall();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_warp_sched.md
# fetch_warp_sched

Per-core warp fetch scheduler. It holds the PC, thread mask and lifecycle state of every warp and picks one eligible warp per cycle, round-robin. It drives the schedule request that the instruction-fetch stage turns into an icache request. Each warp has at most one instruction in flight; decode or execute releases the warp, optionally with a redirected PC or a new thread mask.

## Interface
Parameters:
- NUM_WARPS, 4, warps per core (power of 2, ≥2); NW_WIDTH = max(1, clog2(NUM_WARPS))
- NUM_THREADS, 4, threads per warp
- XLEN, 32, PC width
- UUID_WIDTH, 16, instruction tag width

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-low reset (asserted when 0)
- spawn_valid  input  1  start an inactive warp
- spawn_wid  input  NW_WIDTH  warp to start
- spawn_pc  input  XLEN  start PC
- spawn_tmask  input  NUM_THREADS  start thread mask
- unlock_valid  input  1  release the in-flight instruction of a warp
- unlock_wid  input  NW_WIDTH  warp to release
- unlock_redirect  input  1  load unlock_pc instead of keeping the sequential PC
- unlock_pc  input  XLEN  redirect target
- unlock_tmask_en  input  1  load unlock_tmask
- unlock_tmask  input  NUM_THREADS  new thread mask
- sched_valid  output  1  request valid
- sched_ready  input  1  downstream accepts the request
- sched_wid / sched_pc / sched_tmask / sched_uuid  output  NW_WIDTH / XLEN / NUM_THREADS / UUID_WIDTH  request payload
- active_warps  output  NUM_WARPS  per-warp active flags
- busy  output  1  any warp active or sched_valid high
- perf_idle_cycles, perf_stall_cycles  output  32 each  performance counters

## Operation
- Per-warp state: active, inflight, pc[XLEN], tmask.
- Eligible warp: active and not inflight.
- Output register:
  - Loads when empty (sched_valid=0) or firing (sched_valid & sched_ready).
  - Loads the round-robin winner among eligible warps. The search starts at the warp after the last loaded wid and wraps from NUM_WARPS-1 to 0.
- On load:
  - Payload = {wid, pc, tmask, uuid_ctr}.
  - That warp gets inflight=1 and pc += 4, modulo 2^XLEN.
  - uuid_ctr increments, wrapping at 2^UUID_WIDTH.
- If there is no eligible warp on a fire, sched_valid deasserts.
- Handshake:
  - Payload is stable while sched_valid=1 and sched_ready=0.
  - sched_valid never drops without a fire.
- Spawn:
  - Applies only if the warp is inactive. It sets active=1, inflight=0, pc=spawn_pc, tmask=spawn_tmask.
  - If the warp is already active, the spawn is ignored.
  - spawn_tmask=0 is ignored.
- Unlock:
  - Applies only if the warp is active and inflight. It clears inflight.
  - unlock_redirect=1 loads pc=unlock_pc.
  - unlock_tmask_en=1 loads tmask=unlock_tmask. If unlock_tmask=0, active is cleared (warp terminates).
  - Any other unlock is ignored.
- Simultaneous events:
  - spawn and unlock to the same wid in one cycle: unlock is evaluated first, then spawn. A warp terminated by that unlock is respawned.
  - Unlock of warp W in the same cycle W would otherwise be selected: W is not eligible that cycle (inflight is still 1); it becomes eligible the next cycle.
- Unlock for the warp currently held in the output register is ignored (it is inflight but not yet issued downstream).

## Timing
- Reset values: sched_valid=0, sched payload=0, active_warps=0, busy=0, uuid_ctr=0, RR pointer=NUM_WARPS-1 (so wid 0 wins first), perf counters=0.
- Reset is sampled on the edge. Reset mid-operation discards the held request; sched_valid=0 after that edge.
- Spawn sampled at edge E: warp eligible in the cycle after E; sched_valid=1 after edge E+1.
- Unlock-to-reissue of the same warp: 2 edges.
- With sched_ready held at 1 and k≥2 eligible warps: one fire per cycle, wids in rotating order.
- A single warp can issue at most once per 2 edges after its unlock.

## Configuration
- FETCH_SCHED_PERF_EN defined:
  - perf_idle_cycles increments each cycle with no active warp.
  - perf_stall_cycles increments each cycle with sched_valid=1 and sched_ready=0.
  - Both saturate at 2^32-1 and clear on reset.
- FETCH_SCHED_PERF_EN undefined: both outputs are tied to 0 and no counter logic is built.

## Test plan
- Reset, then spawn wid0 with pc=0x80000000, tmask=4'b1111, sched_ready=1 -> sched_valid=1 after 2 edges with wid0, pc=0x80000000, uuid=0. No second request until unlock.
- Spawn wids 0–3, sched_ready=1, unlock each warp the cycle after its fire -> fire order 0,1,2,3,0,… with uuids incrementing by 1 and each warp's pc stepping by +4.
- Hold sched_ready=0 for 5 cycles with wid2 pending -> payload stable. With FETCH_SCHED_PERF_EN, perf_stall_cycles=5.
- Unlock wid1 with redirect to pc=0x80000100 -> next wid1 request carries 0x80000100, and the following one carries 0x80000104.
- Unlock wid3 with unlock_tmask_en=1, unlock_tmask=0 -> active_warps[3]=0 and wid3 is never scheduled again. Spawn wid3 again -> it resumes.
- Assert reset while sched_valid=1 -> sched_valid=0, active_warps=0, busy=0, uuid restarts at 0.
